prog_loader: RTL and testbench

//  Byte-serial program loader: receives a framed instruction image over a valid/ready

---
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: receives a length/payload/checksum frame over a valid/ready
// stream, writes it into the program RAM, and enables the processor after a clean load.
module prog_loader #(
  parameter int unsigned INSTRS_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic [INSTRS_WIDTH-1:0] instr,
  output logic                    proc_ena,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ADDR_WIDTH:0]     word_count
);

  localparam int unsigned NumBytes = INSTRS_WIDTH / 8;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned CntW     = ADDR_WIDTH + 1;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [16:0] MaxLen   = 17'(Depth);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [7:0]              csum_q, csum_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [INSTRS_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [CntW-1:0]         wcnt_q, wcnt_d;

  logic                    xfer;
  logic                    we;
  logic [15:0]             new_len;
  logic [INSTRS_WIDTH-1:0] word_nxt;

  logic [INSTRS_WIDTH-1:0] mem_q [Depth];

  // Bytes shift in from the top so the first byte of a word ends up in [7:0].
  assign word_nxt = (wbuf_q >> 8) | (INSTRS_WIDTH'(rx_data) << (INSTRS_WIDTH - 8));
  assign new_len  = {rx_data, len_q[7:0]};
  assign xfer     = rx_valid & rx_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    wbuf_d  = wbuf_q;
    wcnt_d  = wcnt_q;
    we      = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start) begin
          state_d = StLenLo;
          len_d   = '0;
          csum_d  = '0;
          idx_d   = '0;
          wcnt_d  = '0;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d   = {8'h00, rx_data};
          csum_d  = csum_q ^ rx_data;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d   = new_len;
          csum_d  = csum_q ^ rx_data;
          state_d = (new_len == 16'd0 || {1'b0, new_len} > MaxLen) ? StErr : StData;
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          wbuf_d = word_nxt;
          if (idx_q == IdxW'(NumBytes - 1)) begin
            idx_d  = '0;
            we     = 1'b1;
            wcnt_d = wcnt_q + CntW'(1);
            if (16'(wcnt_q) + 16'd1 == len_q) state_d = StCsum;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StCsum: begin
        if (xfer) state_d = (rx_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      wbuf_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Program RAM is deliberately not reset; a reset edge must not disturb its contents.
  always_ff @(posedge clk) begin
    if (we && rst_n) mem_q[wcnt_q[ADDR_WIDTH-1:0]] <= word_nxt;
  end

  assign instr      = mem_q[pc];
  assign rx_ready   = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCsum);
  assign load_busy  = rx_ready;
  assign load_done  = (state_q == StDone);
  assign load_err   = (state_q == StErr);
  assign proc_ena   = (state_q == StDone);
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are decoded by a byte-level reference model
// and the loader's status, word count and fetched instructions are compared against it.
module tb_prog_loader;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          proc_ena;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  prog_loader #(
    .INSTRS_WIDTH (IW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pc         (pc),
    .instr      (instr),
    .proc_ena   (proc_ena),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  frame_q[$];
  logic [31:0] model_mem [256];
  bit          exp_done;
  int          exp_wc;
  int          n_consume;

  task automatic model_frame();
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    logic [31:0] w;
    n = int'({frame_q[1], frame_q[0]});
    x = frame_q[0] ^ frame_q[1];
    exp_done  = 1'b0;
    exp_wc    = 0;
    n_consume = 2;
    if (n == 0 || n > 256) return;
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        b = frame_q[2 + k * 4 + j];
        w = w | (32'(b) << (8 * j));
        x = x ^ b;
      end
      model_mem[k] = w;
    end
    exp_wc    = n;
    n_consume = 2 + 4 * n + 1;
    exp_done  = (frame_q[2 + 4 * n] == x);
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] cs;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      cs = cs ^ b;
    end
    frame_q.push_back(bad ? ~cs : cs);
  endtask

  task automatic load_test2_frame(input logic [7:0] cs);
    frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, cs};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse);
    int waited;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    rx_valid   = 1'b1;
    rx_data    = b;
    load_start = pulse;
    waited     = 0;
    while (!rx_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!rx_ready) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else tick();
    rx_valid   = 1'b0;
    load_start = 1'b0;
    rx_data    = 8'($urandom);
  endtask

  task automatic check_status();
    check_eq("load_done", 32'(load_done), 32'(exp_done));
    check_eq("load_err", 32'(load_err), 32'(!exp_done));
    check_eq("proc_ena", 32'(proc_ena), 32'(exp_done));
    check_eq("load_busy", 32'(load_busy), 32'd0);
    check_eq("rx_ready_after", 32'(rx_ready), 32'd0);
    check_eq("word_count", 32'(word_count), 32'(exp_wc));
    for (int k = 0; k < exp_wc; k++) begin
      pc = AW'(k);
      #1;
      check_eq("instr", instr, model_mem[k]);
    end
  endtask

  task automatic run_frame(input bit gaps, input int pulse_at);
    model_frame();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_eq("busy_after_start", 32'(load_busy), 32'd1);
    check_eq("ena_dropped", 32'(proc_ena), 32'd0);
    for (int i = 0; i < n_consume; i++) send_byte(frame_q[i], gaps, i == pulse_at);
    check_status();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    pc         = '0;
    tick();
    tick();
    // Reset state
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_busy", 32'(load_busy), 32'd0);
    check_eq("rst_done", 32'(load_done), 32'd0);
    check_eq("rst_err", 32'(load_err), 32'd0);
    check_eq("rst_ena", 32'(proc_ena), 32'd0);
    check_eq("rst_wc", 32'(word_count), 32'd0);
    rst_n    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (5) tick();
    check_eq("idle_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("idle_busy", 32'(load_busy), 32'd0);
    check_eq("idle_wc", 32'(word_count), 32'd0);
    rx_valid = 1'b0;

    // Known good frame
    load_test2_frame(8'h8A);
    run_frame(1'b0, -1);
    check_eq("t2_mem0", model_mem[0], 32'h44332211);
    check_eq("t2_mem1", model_mem[1], 32'h88776655);

    // Bad checksum
    load_test2_frame(8'h8B);
    run_frame(1'b0, -1);
    pc = '0;
    #1;
    check_eq("t3_instr0", instr, 32'h44332211);

    // Length boundaries
    frame_q = '{8'h00, 8'h00};
    run_frame(1'b0, -1);
    frame_q = '{8'h01, 8'h01};
    run_frame(1'b0, -1);
    build_frame(256, 1'b0);
    run_frame(1'b0, -1);
    pc = 8'hFF;
    #1;
    check_eq("t4_mem255", instr, model_mem[255]);

    // Gaps plus an ignored load_start mid-DATA
    load_test2_frame(8'h8A);
    run_frame(1'b1, 5);

    // Reset mid-frame, then a full reload
    load_test2_frame(8'h8A);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(load_busy), 32'd0);
    check_eq("mid_rst_done", 32'(load_done), 32'd0);
    check_eq("mid_rst_err", 32'(load_err), 32'd0);
    check_eq("mid_rst_ena", 32'(proc_ena), 32'd0);
    check_eq("mid_rst_wc", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick();
    run_frame(1'b0, -1);

    // Random frames
    repeat (8) begin
      build_frame(int'($urandom_range(1, 16)), $urandom_range(0, 3) == 0);
      run_frame(1'b1, ($urandom_range(0, 1) == 1) ? 3 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
